vga_scan_gen: RTL

- Raster timing generator that produces the H_pos/V_pos scan coordinates consumed by the sprite lookup logic, plus hsync/vsync and the active-video qualifier for the VGA output stage.
- Owns the pixel-clock enable, horizontal/vertical counters and blanking phase state machines.
- All outputs are registered, so downstream combinational pixel logic sees stable coordinates for a full pixel period.

---
 rtl/scan_pkg.sv | 30 +++
 rtl/scan_axis_fsm.sv | 61 ++++++
 rtl/vga_scan_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// Shared raster-scan types and default 320x240 timing, also used by the sprite logic.
package scan_pkg;

  localparam int POS_W     = 9;
  localparam int POS_LIMIT = 512;
  localparam int DIV_W     = 4;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FP     = 8;
  localparam int DEF_H_SYNC   = 48;
  localparam int DEF_H_BP     = 24;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 17;

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} scan_state_t;

  // Zero-width phases fall through naturally, so empty states are skipped.
  function automatic scan_state_t phase_of(input logic [POS_W-1:0] pos,
                                           input int act, input int fp, input int syn);
    int p;
    p = int'(pos);
    if (p < act)                 return ACTIVE;
    else if (p < act + fp)       return FRONT;
    else if (p < act + fp + syn) return SYNC;
    else                         return BACK;
  endfunction

endpackage

// File: rtl/scan_axis_fsm.sv
// One scan axis: position counter, blanking phase FSM and registered sync output.
module scan_axis_fsm
  import scan_pkg::*;
#(
  parameter int   P_ACTIVE = DEF_H_ACTIVE,
  parameter int   P_FP     = DEF_H_FP,
  parameter int   P_SYNC   = DEF_H_SYNC,
  parameter int   P_BP     = DEF_H_BP,
  parameter logic P_POL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  output logic [POS_W-1:0] pos_o,
  output logic [POS_W-1:0] pos_nxt_o,
  output logic             sync_o,
  output logic             wrap_o
);

  localparam int               TOTAL = P_ACTIVE + P_FP + P_SYNC + P_BP;
  localparam logic [POS_W-1:0] LAST  = POS_W'(TOTAL - 1);

  logic [POS_W-1:0] pos_q, pos_d;
  scan_state_t      state_q, state_d;
  logic             sync_q, sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q   <= '0;
      state_q <= ACTIVE;
      sync_q  <= ~P_POL;
    end else begin
      pos_q   <= pos_d;
      state_q <= state_d;
      sync_q  <= sync_d;
    end
  end

  // Phase and sync are derived from the next position so they land on the same edge.
  always_comb begin
    pos_d   = pos_q;
    state_d = state_q;
    sync_d  = sync_q;
    wrap_o  = 1'b0;
    if (advance_i) begin
      if (pos_q == LAST) begin
        pos_d  = '0;
        wrap_o = 1'b1;
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
      state_d = phase_of(pos_d, P_ACTIVE, P_FP, P_SYNC);
      sync_d  = (state_d == SYNC) ? P_POL : ~P_POL;
    end
  end

  assign pos_o     = pos_q;
  assign pos_nxt_o = pos_d;
  assign sync_o    = sync_q;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: pixel-clock enable, H/V scan counters and registered qualifiers.
module vga_scan_gen
  import scan_pkg::*;
#(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [POS_W-1:0] H_pos,
  output logic [POS_W-1:0] V_pos,
  output logic             pix_en,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int               H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int               V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > POS_LIMIT) begin : g_h_total_chk
    $fatal(1, "vga_scan_gen: H_TOTAL exceeds 512");
  end
  if (V_TOTAL > POS_LIMIT) begin : g_v_total_chk
    $fatal(1, "vga_scan_gen: V_TOTAL exceeds 512");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_chk
    $fatal(1, "vga_scan_gen: CLK_DIV out of range 1..16");
  end

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pix_en_q, pix_en_d;
  logic             active_q, active_d;
  logic             line_q, line_d;
  logic             frame_q, frame_d;
  logic [POS_W-1:0] h_nxt, v_nxt;
  logic             h_wrap, v_wrap;

  // A strobe already presented downstream always commits its advance, even if en drops.
  scan_axis_fsm #(
    .P_ACTIVE(H_ACTIVE), .P_FP(H_FP), .P_SYNC(H_SYNC), .P_BP(H_BP), .P_POL(HS_POL)
  ) u_h_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance_i(pix_en_q),
    .pos_o    (H_pos),
    .pos_nxt_o(h_nxt),
    .sync_o   (hsync),
    .wrap_o   (h_wrap)
  );

  scan_axis_fsm #(
    .P_ACTIVE(V_ACTIVE), .P_FP(V_FP), .P_SYNC(V_SYNC), .P_BP(V_BP), .P_POL(VS_POL)
  ) u_v_axis (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance_i(h_wrap),
    .pos_o    (V_pos),
    .pos_nxt_o(v_nxt),
    .sync_o   (vsync),
    .wrap_o   (v_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pix_en_q <= 1'b0;
      active_q <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pix_en_q <= pix_en_d;
      active_q <= active_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    pix_en_d = 1'b0;
    active_d = active_q;
    line_d   = line_q;
    frame_d  = frame_q;
    if (en) begin
      cnt_d    = (cnt_q == DIV_LAST) ? '0 : cnt_q + DIV_W'(1);
      pix_en_d = (cnt_q == DIV_LAST);
    end
    if (pix_en_q) begin
      active_d = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
      line_d   = h_wrap;
      frame_d  = v_wrap;
    end
    if (!en) begin
      line_d  = 1'b0;
      frame_d = 1'b0;
    end
  end

  assign pix_en      = pix_en_q;
  assign active      = active_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule
